display_select_sequencer: RTL and testbench

- Drives the debug display mux from its input side. Generates `Display_Select` and `Display_Enable` from board pushbuttons, switches and an optional auto-scan timer.
- Captures the mux's returned `HexDisplay32Bits` into a stable snapshot for the seven-segment drivers.
- Sits at top level between board I/O and the display mux. Replaces hand-set select switches.

---
 rtl/display_debug_pkg.sv | 26 ++
 rtl/display_select_sequencer_if.sv | 30 +++
 rtl/button_debouncer.sv | 57 +++++
 rtl/display_select_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_display_select_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_debug_pkg
//  Purpose  : Shared constants and types for the debug display path. The
//             select width and the normal/debug index ranges live here so
//             that the sequencer and the display mux agree on one source.
//  Revision : 1.0 - initial release
// ============================================================================
package display_debug_pkg;

    localparam int DISPLAY_SEL_W = 6;

    // Normal range is 0..NORMAL_LAST, debug range is DEBUG_BASE..DEBUG_LAST.
    // DEBUG_BASE is also the offset the mux uses for its debug registers.
    localparam int NORMAL_LAST = 26;
    localparam int DEBUG_BASE  = 32;
    localparam int DEBUG_LAST  = 37;

    // Snapshot capture state machine
    typedef enum logic [0:0] {
        CAP_SETTLE = 1'b0,
        CAP_VALID  = 1'b1
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/display_select_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : display_select_sequencer_if
//  Purpose  : Link between the select sequencer and the debug display mux.
//  Signals  : Display_Select   - select index sent to the mux
//             Display_Enable   - 0: mux drives the display, 1: blanked
//             HexDisplay32Bits - value returned by the mux
//  Modports : master - sequencer side, slave - mux side
//  Revision : 1.0 - initial release
// ============================================================================
interface display_select_sequencer_if;
    import display_debug_pkg::*;

    logic [DISPLAY_SEL_W-1:0] Display_Select;
    logic                     Display_Enable;
    logic [31:0]              HexDisplay32Bits;

    modport master (
        output Display_Select,
        output Display_Enable,
        input  HexDisplay32Bits
    );

    modport slave (
        input  Display_Select,
        input  Display_Enable,
        output HexDisplay32Bits
    );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : button_debouncer
//  Purpose  : 2-FF synchronizer, debounce counter and press-event generator
//             for one active-low pushbutton.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_button_n    - raw active-low button pin
//             o_press       - one-cycle pulse on accepted press (1->0)
//  Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button_n,
    output logic o_press
);
    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the accepted level;
    // the level flips on the DEBOUNCE_CYCLES-th such sample. The press pulse
    // is registered together with the level so it lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_button_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign o_press = r_press;
endmodule
`default_nettype wire

// File: rtl/display_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : display_select_sequencer
//  Purpose  : Generates the display mux select/enable from pushbuttons,
//             switches and an auto-scan timer, and keeps a stable snapshot
//             of the value the mux returns.
//  Ports    : Clock, Reset            - clock, synchronous active-high reset
//             Step_n, Back_n          - active-low step forward / backward
//             Debug_Mode              - 1: debug range, 0: normal range
//             Auto_Enable, Freeze     - auto-scan enable, hold select+snapshot
//             mux (master)            - Display_Select/Enable, HexDisplay32Bits
//             Snapshot/Snapshot_Valid - captured mux value and its validity
//             Wrap_Pulse              - one-cycle pulse when the select wraps
//  Revision : 1.0 - initial release
// ============================================================================
module display_select_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DWELL_CYCLES    = 50000000,
    parameter int NORMAL_LAST     = display_debug_pkg::NORMAL_LAST,
    parameter int DEBUG_BASE      = display_debug_pkg::DEBUG_BASE,
    parameter int DEBUG_LAST      = display_debug_pkg::DEBUG_LAST,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic                              Step_n,
    input  logic                              Back_n,
    input  logic                              Debug_Mode,
    input  logic                              Auto_Enable,
    input  logic                              Freeze,
    display_select_sequencer_if.master        mux,
    output logic [31:0]                       Snapshot,
    output logic                              Snapshot_Valid,
    output logic                              Wrap_Pulse
);
    import display_debug_pkg::*;

    generate
        if (NORMAL_LAST < 0 || NORMAL_LAST > 63 || DEBUG_BASE < 0 || DEBUG_BASE > 63 ||
            DEBUG_LAST > 63 || DEBUG_BASE > DEBUG_LAST) begin : g_range_check
            $error("display_select_sequencer: select range parameters out of 0..63");
        end
    endgenerate

    localparam int c_dwell_w  = $clog2(DWELL_CYCLES + 1);
    localparam int c_settle_w = $clog2(SETTLE_CYCLES + 2);

    localparam logic [DISPLAY_SEL_W-1:0] c_normal_base = '0;
    localparam logic [DISPLAY_SEL_W-1:0] c_normal_last = DISPLAY_SEL_W'(NORMAL_LAST);
    localparam logic [DISPLAY_SEL_W-1:0] c_debug_base  = DISPLAY_SEL_W'(DEBUG_BASE);
    localparam logic [DISPLAY_SEL_W-1:0] c_debug_last  = DISPLAY_SEL_W'(DEBUG_LAST);
    localparam logic [DISPLAY_SEL_W-1:0] c_sel_one     = DISPLAY_SEL_W'(1);
    localparam logic [c_dwell_w-1:0]     c_dwell_last  = c_dwell_w'(DWELL_CYCLES - 1);
    localparam logic [c_dwell_w-1:0]     c_dwell_one   = c_dwell_w'(1);
    localparam logic [c_settle_w-1:0]    c_settle_last = c_settle_w'(SETTLE_CYCLES);
    localparam logic [c_settle_w-1:0]    c_settle_one  = c_settle_w'(1);

    logic                     w_step_evt;
    logic                     w_back_evt;
    logic                     r_mode_s1;
    logic                     r_mode_s2;
    logic                     r_mode;
    logic                     w_mode_next;
    logic [DISPLAY_SEL_W-1:0] r_sel;
    logic [DISPLAY_SEL_W-1:0] w_sel_next;
    logic [DISPLAY_SEL_W-1:0] w_base;
    logic [DISPLAY_SEL_W-1:0] w_last;
    logic                     r_wrap;
    logic                     w_wrap_next;
    logic                     r_enable;
    logic [c_dwell_w-1:0]     r_dwell;
    logic [c_dwell_w-1:0]     w_dwell_next;
    logic                     w_expire;
    logic                     w_sel_change;
    cap_state_t               r_state;
    cap_state_t               w_state_next;
    logic [c_settle_w-1:0]    r_settle;
    logic [c_settle_w-1:0]    w_settle_next;
    logic                     w_capture;
    logic [31:0]              r_snapshot;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk        (Clock),
        .rst        (Reset),
        .i_button_n (Step_n),
        .o_press    (w_step_evt)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
        .clk        (Clock),
        .rst        (Reset),
        .i_button_n (Back_n),
        .o_press    (w_back_evt)
    );

    // r_mode is the range currently in use; a difference against the
    // synchronized switch is what triggers the base load.
    assign w_base   = r_mode ? c_debug_base : c_normal_base;
    assign w_last   = r_mode ? c_debug_last : c_normal_last;
    assign w_expire = Auto_Enable && !Freeze && (r_dwell == c_dwell_last);

    always_comb begin
        w_sel_next  = r_sel;
        w_wrap_next = 1'b0;
        w_mode_next = r_mode;
        // Freeze also defers a pending mode change, so the select never moves
        // while frozen and always stays inside the range of r_mode.
        if (!Freeze) begin
            if (r_mode_s2 != r_mode) begin
                w_mode_next = r_mode_s2;
                w_sel_next  = r_mode_s2 ? c_debug_base : c_normal_base;
            end else if (w_step_evt && w_back_evt) begin
                w_sel_next = r_sel;
            end else if (w_step_evt || w_expire) begin
                if (r_sel == w_last) begin
                    w_sel_next  = w_base;
                    w_wrap_next = 1'b1;
                end else begin
                    w_sel_next = r_sel + c_sel_one;
                end
            end else if (w_back_evt) begin
                if (r_sel == w_base) begin
                    w_sel_next  = w_last;
                    w_wrap_next = 1'b1;
                end else begin
                    w_sel_next = r_sel - c_sel_one;
                end
            end
        end
    end

    assign w_sel_change = (w_sel_next != r_sel);

    always_comb begin
        w_dwell_next = r_dwell + c_dwell_one;
        if (!Auto_Enable) begin
            w_dwell_next = '0;
        end else if (Freeze) begin
            w_dwell_next = r_dwell;
        end else if (w_sel_change || w_expire) begin
            w_dwell_next = '0;
        end
    end

    // Mode synchronizers load the raw switch during reset so that leaving
    // reset never looks like a mode change.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mode_s1 <= Debug_Mode;
            r_mode_s2 <= Debug_Mode;
            r_mode    <= Debug_Mode;
            r_sel     <= Debug_Mode ? c_debug_base : c_normal_base;
            r_wrap    <= 1'b0;
            r_enable  <= 1'b1;
            r_dwell   <= '0;
        end else begin
            r_mode_s1 <= Debug_Mode;
            r_mode_s2 <= r_mode_s1;
            r_mode    <= w_mode_next;
            r_sel     <= w_sel_next;
            r_wrap    <= w_wrap_next;
            r_enable  <= 1'b0;
            r_dwell   <= w_dwell_next;
        end
    end

    // Capture FSM. A select change on this edge always restarts settling,
    // so Snapshot_Valid drops in the same cycle the select moves.
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_capture     = 1'b0;
        if (w_sel_change) begin
            w_state_next  = CAP_SETTLE;
            w_settle_next = '0;
        end else begin
            case (r_state)
                CAP_SETTLE: begin
                    if (r_settle == c_settle_last) begin
                        if (!Freeze) begin
                            w_capture    = 1'b1;
                            w_state_next = CAP_VALID;
                        end
                    end else begin
                        w_settle_next = r_settle + c_settle_one;
                    end
                end
                CAP_VALID: begin
                    w_capture = !Freeze;
                end
                default: begin
                    w_state_next = CAP_SETTLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= CAP_SETTLE;
            r_settle   <= '0;
            r_snapshot <= '0;
        end else begin
            r_state  <= w_state_next;
            r_settle <= w_settle_next;
            if (w_capture) begin
                r_snapshot <= mux.HexDisplay32Bits;
            end
        end
    end

    assign mux.Display_Select = r_sel;
    assign mux.Display_Enable = r_enable;
    assign Snapshot           = r_snapshot;
    assign Snapshot_Valid     = (r_state == CAP_VALID);
    assign Wrap_Pulse         = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_display_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_select_sequencer
//  Purpose  : Self-checking bench for display_select_sequencer. Stimulus
//             pushes expected select moves and snapshots into queues; a
//             monitor pops them whenever the select changes or the snapshot
//             becomes valid. The mux is modelled as hex_base ^ select.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display_select_sequencer;

    typedef struct {
        logic [5:0] sel;
        logic       wrap;
    } sel_exp_t;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Step_n;
    logic        Back_n;
    logic        Debug_Mode;
    logic        Auto_Enable;
    logic        Freeze;
    logic [31:0] Snapshot;
    logic        Snapshot_Valid;
    logic        Wrap_Pulse;
    logic [31:0] hex_base;

    sel_exp_t    sel_q[$];
    logic [31:0] snap_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    display_select_sequencer_if bus();
    assign bus.HexDisplay32Bits = hex_base ^ {26'd0, bus.Display_Select};

    display_select_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .DWELL_CYCLES    (10),
        .SETTLE_CYCLES   (2)
    ) dut (
        .Clock          (clk),
        .Reset          (Reset),
        .Step_n         (Step_n),
        .Back_n         (Back_n),
        .Debug_Mode     (Debug_Mode),
        .Auto_Enable    (Auto_Enable),
        .Freeze         (Freeze),
        .mux            (bus.master),
        .Snapshot       (Snapshot),
        .Snapshot_Valid (Snapshot_Valid),
        .Wrap_Pulse     (Wrap_Pulse)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_move(input logic [5:0] sel, input logic wrap);
        sel_exp_t e;
        e.sel  = sel;
        e.wrap = wrap;
        sel_q.push_back(e);
        snap_q.push_back(hex_base ^ 32'(sel));
    endtask

    task automatic press(input logic st, input logic bk);
        Step_n = ~st;
        Back_n = ~bk;
        tick(8);
        Step_n = 1'b1;
        Back_n = 1'b1;
        tick(10);
    endtask

    // Monitor: every select change must match the next queued move (value
    // and wrap pulse); every rise of Snapshot_Valid must match the next
    // queued snapshot.
    initial begin : monitor
        logic [5:0] prev_sel;
        logic       prev_valid;
        sel_exp_t   e;
        prev_sel   = '0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (Reset !== 1'b1) begin
                if (bus.Display_Select !== prev_sel) begin
                    if (sel_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_select: got %0d expected no change (t=%0t)",
                                 bus.Display_Select, $time);
                    end else begin
                        e = sel_q.pop_front();
                        chk("select", 32'(bus.Display_Select), 32'(e.sel));
                        chk("wrap_pulse", 32'(Wrap_Pulse), 32'(e.wrap));
                    end
                end else if (Wrap_Pulse !== 1'b0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_wrap: got %b expected 0 (t=%0t)", Wrap_Pulse, $time);
                end
                if (Snapshot_Valid === 1'b1 && prev_valid !== 1'b1) begin
                    if (snap_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid: got snapshot %h expected none (t=%0t)",
                                 Snapshot, $time);
                    end else begin
                        chk("snapshot_at_valid", Snapshot, snap_q.pop_front());
                    end
                end
            end
            prev_sel   = bus.Display_Select;
            prev_valid = Snapshot_Valid;
        end
    end

    initial begin : stimulus
        Reset       = 1'b1;
        Step_n      = 1'b1;
        Back_n      = 1'b1;
        Debug_Mode  = 1'b0;
        Auto_Enable = 1'b0;
        Freeze      = 1'b0;
        hex_base    = 32'h0000_0003;

        // Reset state
        tick(3);
        chk("reset_select", 32'(bus.Display_Select), 32'd0);
        chk("reset_enable", 32'(bus.Display_Enable), 32'd1);
        chk("reset_snapshot", Snapshot, 32'd0);
        chk("reset_valid", 32'(Snapshot_Valid), 32'd0);
        chk("reset_wrap", 32'(Wrap_Pulse), 32'd0);

        snap_q.push_back(32'h0000_0003);
        Reset = 1'b0;
        tick(1);
        chk("enable_after_reset", 32'(bus.Display_Enable), 32'd0);
        chk("valid_cycle1", 32'(Snapshot_Valid), 32'd0);
        tick(1);
        chk("valid_cycle2", 32'(Snapshot_Valid), 32'd0);
        tick(1);
        chk("valid_cycle3", 32'(Snapshot_Valid), 32'd1);

        // 2-cycle bounce must be rejected
        Step_n = 1'b0;
        tick(2);
        Step_n = 1'b1;
        tick(12);
        chk("bounce_select", 32'(bus.Display_Select), 32'd0);

        // Long press: single increment after DEBOUNCE+3 cycles
        expect_move(6'd1, 1'b0);
        Step_n = 1'b0;
        tick(6);
        chk("latency_before", 32'(bus.Display_Select), 32'd0);
        tick(1);
        chk("latency_after", 32'(bus.Display_Select), 32'd1);
        tick(13);
        Step_n = 1'b1;
        tick(10);

        for (int i = 2; i <= 5; i++) begin
            expect_move(6'(i), 1'b0);
            press(1'b1, 1'b0);
        end

        // Auto-scan from 5, then a manual step landing on the expiry cycle
        expect_move(6'd6, 1'b0);
        expect_move(6'd7, 1'b0);
        expect_move(6'd8, 1'b0);
        Auto_Enable = 1'b1;
        tick(9);
        chk("dwell_before", 32'(bus.Display_Select), 32'd5);
        tick(1);
        chk("dwell_first", 32'(bus.Display_Select), 32'd6);
        tick(10);
        chk("dwell_second", 32'(bus.Display_Select), 32'd7);
        tick(3);
        Step_n = 1'b0;
        tick(7);
        chk("step_on_expiry", 32'(bus.Display_Select), 32'd8);
        tick(1);
        chk("single_advance", 32'(bus.Display_Select), 32'd8);
        Auto_Enable = 1'b0;
        Step_n      = 1'b1;
        tick(10);

        for (int i = 9; i <= 26; i++) begin
            expect_move(6'(i), 1'b0);
            press(1'b1, 1'b0);
        end
        expect_move(6'd0, 1'b1);
        press(1'b1, 1'b0);

        // Freeze holds select and snapshot while the mux value changes
        tick(2);
        Freeze   = 1'b1;
        hex_base = 32'hAAAA_0000;
        tick(2);
        chk("freeze_snapshot", Snapshot, 32'h0000_0003);
        hex_base = 32'h5555_FFFF;
        press(1'b1, 1'b0);
        chk("freeze_select", 32'(bus.Display_Select), 32'd0);
        chk("freeze_snapshot2", Snapshot, 32'h0000_0003);
        Freeze = 1'b0;
        tick(1);
        chk("unfreeze_snapshot", Snapshot, 32'h5555_FFFF);

        // Back wrap in the normal range and back again
        expect_move(6'd26, 1'b1);
        press(1'b0, 1'b1);
        expect_move(6'd0, 1'b1);
        press(1'b1, 1'b0);

        for (int i = 1; i <= 12; i++) begin
            expect_move(6'(i), 1'b0);
            press(1'b1, 1'b0);
        end

        // Mode change loads the debug base three cycles later, no wrap
        expect_move(6'd32, 1'b0);
        Debug_Mode = 1'b1;
        tick(2);
        chk("mode_before", 32'(bus.Display_Select), 32'd12);
        tick(1);
        chk("mode_load", 32'(bus.Display_Select), 32'd32);
        chk("mode_valid_drop", 32'(Snapshot_Valid), 32'd0);
        tick(5);

        // Debug range wraps in both directions
        expect_move(6'd37, 1'b1);
        press(1'b0, 1'b1);
        expect_move(6'd32, 1'b1);
        press(1'b1, 1'b0);

        // Step and Back together: no movement
        press(1'b1, 1'b1);
        chk("both_select", 32'(bus.Display_Select), 32'd32);

        // Reset in debug mode
        Reset = 1'b1;
        tick(2);
        chk("reset_debug_select", 32'(bus.Display_Select), 32'd32);
        chk("reset_debug_enable", 32'(bus.Display_Enable), 32'd1);
        chk("reset_debug_valid", 32'(Snapshot_Valid), 32'd0);
        snap_q.push_back(32'h5555_FFDF);
        Reset = 1'b0;
        tick(6);

        chk("sel_queue_empty", 32'(sel_q.size()), 32'd0);
        chk("snap_queue_empty", 32'(snap_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
